// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one UART transmitter between N_REQ byte sources.
// Each granted byte is handed over through a tx_start/tx_busy handshake.
//
// state | meaning
// IDLE  | choosing the next byte; when locked, only the current owner is eligible
// START | tx_start held high, waiting for the transmitter to report busy
// SEND  | frame in flight, waiting for the transmitter to go idle
module uart_tx_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8,
  parameter int ID_W   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [ID_W-1:0]         grant_id,
  output logic                    locked,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, START, SEND} state_t;

  state_t            state, state_n;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_n, grant_id_n;
  logic [N_REQ-1:0]  ack_n;
  logic [DATA_W-1:0] tx_data_n;
  logic              tx_start_n, locked_n;
  logic              found;
  int                win;
  int                cand;

  // Scan from rr_ptr upward; a held lock narrows eligibility to the owner.
  always_comb begin
    found = 1'b0;
    win   = 0;
    cand  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req[cand] && (!locked || cand == int'(grant_id))) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
      ack      <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      grant_id <= grant_id_n;
      locked   <= locked_n;
      ack      <= ack_n;
      tx_data  <= tx_data_n;
      tx_start <= tx_start_n;
    end
  end

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    grant_id_n = grant_id;
    locked_n   = locked;
    ack_n      = '0;
    tx_data_n  = tx_data;
    tx_start_n = tx_start;
    case (state)
      IDLE: begin
        if (found) begin
          tx_data_n  = req_data[win*DATA_W +: DATA_W];
          tx_start_n = 1'b1;
          ack_n[win] = 1'b1;
          grant_id_n = ID_W'(win);
          locked_n   = ~req_last[win];
          if (req_last[win])
            rr_ptr_n = ID_W'((win + 1) % N_REQ);
          state_n = START;
        end
      end
      START: begin
        // Busy already high on entry still leaves after one cycle, so no double start.
        if (tx_busy) begin
          tx_start_n = 1'b0;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (!tx_busy)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE) || locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester traffic, a transmitter stub,
// and a monitor that checks every started byte against the expected grant order.
module tb_uart_tx_arbiter;
  localparam int N_REQ  = 2;
  localparam int DATA_W = 8;
  localparam int ID_W   = 3;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        req_last = '0;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_start;
  logic                    tx_busy = 1'b0;
  logic [ID_W-1:0]         grant_id;
  logic                    locked;
  logic                    busy;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .locked(locked), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  int stub_dly = 2;
  int stub_len = 10;
  bit preload = 0;
  int stub_phase = 0;
  int stub_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int data, input int len);
    exp_t e;
    e.id = id; e.data = data; e.len = len;
    sb.push_back(e);
  endtask

  // Transmitter stub: raises tx_busy stub_dly cycles after seeing tx_start, holds it stub_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        tx_busy = 1'b0; stub_phase = 0; stub_cnt = 0;
      end else begin
        case (stub_phase)
          0: begin
            if (preload) begin
              preload = 0; tx_busy = 1'b1; stub_phase = 2; stub_cnt = stub_len;
            end else if (tx_start) begin
              if (stub_dly == 0) begin
                tx_busy = 1'b1; stub_phase = 2; stub_cnt = stub_len;
              end else begin
                stub_phase = 1; stub_cnt = stub_dly;
              end
            end
          end
          1: begin
            stub_cnt--;
            if (stub_cnt == 0) begin
              tx_busy = 1'b1; stub_phase = 2; stub_cnt = stub_len;
            end
          end
          default: begin
            stub_cnt--;
            if (stub_cnt == 0) begin
              tx_busy = 1'b0; stub_phase = 0;
            end
          end
        endcase
      end
    end
  end

  bit   mon_prev = 0;
  int   mon_run = 0;
  int   cur_len = -1;
  exp_t cur;

  // Monitor: each rising tx_start pops one expected byte; its high time is checked on the fall.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_prev = 0; mon_run = 0; cur_len = -1;
      end else begin
        if (tx_start && !mon_prev) begin
          mon_run = 0;
          if (sb.size() == 0) begin
            checks++; failures++; cur_len = -1;
            $display("FAIL sb_unexpected actual=byte %0h from %0d required=no byte", tx_data, grant_id);
          end else begin
            cur = sb.pop_front();
            cur_len = cur.len;
            chk("sb_data", tx_data, cur.data);
            chk("sb_grant", grant_id, cur.id);
            chk("sb_ack", ack, 1 << cur.id);
          end
        end else if (ack != '0) begin
          checks++; failures++;
          $display("FAIL spurious_ack actual=%0h required=0", ack);
        end
        if (tx_start) mon_run++;
        if (!tx_start && mon_prev && cur_len >= 0) chk("start_len", mon_run, cur_len);
        mon_prev = tx_start;
      end
    end
  end

  task automatic send_byte(input int id, input logic [7:0] d, input logic last,
                           input int tmo, output int lat);
    bit got = 0;
    req_data[id*DATA_W +: DATA_W] = d;
    req_last[id] = last;
    req[id] = 1'b1;
    lat = 0;
    while (!got && lat < tmo) begin
      @(negedge clk);
      lat++;
      if (ack[id]) got = 1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL ack_timeout req=%0d actual=no ack required=ack", id);
    end else begin
      chk("lock_at_ack", locked, !last);
    end
  endtask

  task automatic drop(input int id);
    req[id] = 1'b0;
    req_last[id] = 1'b0;
  endtask

  task automatic wait_idle(input int tmo);
    int n = 0;
    while ((busy || tx_busy || stub_phase != 0) && n < tmo) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy || tx_busy || stub_phase != 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; req_last = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int lat;
  int rises;
  bit prev_s;
  int n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_ack", ack, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 0);
    reset = 1'b0;

    // single byte
    push(0, 'h41, 3);
    @(negedge clk);
    send_byte(0, 8'h41, 1'b1, 20, lat);
    chk("t1_latency", lat, 1);
    chk("t1_busy_in_start", busy, 1);
    drop(0);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("t1_busy_dropped", busy, 0);
    chk("t1_txbusy_low_at_idle", tx_busy, 0);
    wait_idle(100);

    // contention, both last=1
    apply_reset();
    push(0, 'h30, 3); push(1, 'h31, 3); push(0, 'h30, 3); push(1, 'h31, 3);
    fork
      begin int l; send_byte(0, 8'h30, 1'b1, 200, l); send_byte(0, 8'h30, 1'b1, 200, l); drop(0); end
      begin int l; send_byte(1, 8'h31, 1'b1, 200, l); send_byte(1, 8'h31, 1'b1, 200, l); drop(1); end
    join
    wait_idle(100);

    // packet lock; req0 re-requests after CR and must lose to req1
    apply_reset();
    push(0, 'h48, 3); push(0, 'h49, 3); push(0, 'h0D, 3); push(1, 'h58, 3); push(0, 'h21, 3);
    fork
      begin
        int l;
        send_byte(0, 8'h48, 1'b0, 200, l);
        send_byte(0, 8'h49, 1'b0, 200, l);
        send_byte(0, 8'h0D, 1'b1, 200, l);
        send_byte(0, 8'h21, 1'b1, 200, l);
        drop(0);
      end
      begin int l; send_byte(1, 8'h58, 1'b1, 400, l); drop(1); end
    join
    wait_idle(100);

    // locked stall
    apply_reset();
    push(0, 'h50, 3); push(0, 'h51, 3); push(1, 'h59, 3);
    fork
      begin
        int l;
        send_byte(0, 8'h50, 1'b0, 50, l);
        drop(0);
        prev_s = tx_start; rises = 0;
        repeat (50) begin
          @(negedge clk);
          if (tx_start && !prev_s) rises++;
          prev_s = tx_start;
        end
        chk("t4_no_start", rises, 0);
        chk("t4_locked", locked, 1);
        chk("t4_busy", busy, 1);
        send_byte(0, 8'h51, 1'b1, 50, l);
        drop(0);
      end
      begin int l; send_byte(1, 8'h59, 1'b1, 400, l); drop(1); end
    join
    wait_idle(100);

    // reset mid-frame, with rr_ptr and lock both non-zero beforehand
    apply_reset();
    push(0, 'h61, 3); push(1, 'h62, 3); push(0, 'h63, 3); push(1, 'h64, 3);
    send_byte(0, 8'h61, 1'b1, 50, lat);
    drop(0);
    wait_idle(100);
    send_byte(1, 8'h62, 1'b0, 50, lat);
    reset = 1'b1;
    drop(1);
    #1;
    chk("t5_tx_start", tx_start, 0);
    chk("t5_ack", ack, 0);
    chk("t5_locked", locked, 0);
    chk("t5_grant", grant_id, 0);
    chk("t5_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fork
      begin int l; send_byte(0, 8'h63, 1'b1, 100, l); drop(0); end
      begin int l; send_byte(1, 8'h64, 1'b1, 100, l); drop(1); end
    join
    wait_idle(100);

    // transmitter already busy when the byte starts
    apply_reset();
    stub_len = 6;
    preload = 1;
    repeat (2) @(negedge clk);
    chk("t6_preload", tx_busy, 1);
    push(0, 'h45, 1);
    send_byte(0, 8'h45, 1'b1, 20, lat);
    chk("t6_latency", lat, 1);
    drop(0);
    wait_idle(100);
    stub_len = 10;

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter between N_REQ byte sources, for example the LFSR ASCII stream and a banner/status message source.
- Grants are round-robin at packet granularity. Once a requester wins, the grant stays locked to it until it sends a byte flagged last.
- Sits between the requesters and the transmitter's transmit/data inputs, and sequences each byte through a start/busy handshake.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 8, byte width to the transmitter.
- ID_W, 3, width of grant_id; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester byte-valid, level.
- req_data  in  N_REQ*DATA_W  flattened bytes; requester i uses bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  byte is the final byte of its packet.
- ack  out  N_REQ  one-cycle pulse: requester's byte accepted.
- tx_data  out  DATA_W  byte to transmitter, registered.
- tx_start  out  1  level start request to transmitter.
- tx_busy  in  1  transmitter frame in progress.
- grant_id  out  ID_W  index of the current or last owner.
- locked  out  1  packet in progress (grant held).
- busy  out  1  state != IDLE or locked.

Behaviour:
- Reset (async): all outputs 0, state IDLE, rr_ptr=0, lock cleared.
- States: IDLE, START, SEND.
- IDLE:
  - Unlocked: winner = first asserted req scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Locked: only req[grant_id] is eligible; other requests are ignored, with no timeout.
  - On a winner at edge n, at n+1: tx_data<=winner's byte, tx_start=1, ack[winner]=1 for exactly one cycle, grant_id<=winner, state->START.
  - Lock update at the same edge: locked<=~req_last[winner].
  - If req_last[winner]=1: rr_ptr<=(winner+1) mod N_REQ. Otherwise rr_ptr is unchanged.
- START: hold tx_start=1 and tx_data stable until tx_busy=1 is sampled. Then tx_start<=0 and state->SEND.
- SEND: wait for tx_busy=0, then state->IDLE. The next grant can occur in the IDLE cycle that follows, so the minimum gap is 1 clk.
- Requester rules:
  - Hold req, req_data and req_last stable until ack.
  - The cycle after ack, the requester may present its next byte or drop req.
  - Dropping req before ack is allowed; the byte is simply not sent.
- req is sampled only in IDLE. Changes during START/SEND have no effect.
- tx_busy already 1 on entry to START: exit START on the next edge; never double-start.
- Locked owner idle: the arbiter waits indefinitely in IDLE, locked=1, busy=1. This is intentional so packets are never interleaved.
- N_REQ=1 degenerates to pass-through with the handshake intact.
- Reset mid-operation: tx_start drops immediately, and lock and rr_ptr clear. The transmitter is reset by the same reset.

Test Plan:
- Single byte: req[0]=1, req_data=0x41, last=1, stub tx_busy high 2 clks after tx_start for 10 clks. Expect:
  - ack[0] one pulse at n+1; tx_data=0x41.
  - tx_start falls the clk after tx_busy rises; busy=0 after tx_busy falls.
- Contention, N_REQ=2: both req held, last=1, bytes 0x30/0x31. Expect grant order 0,1,0,1; tx_data sequence 0x30,0x31,0x30,0x31; exactly one ack per byte.
- Packet lock: req0 sends "H","I",CR with last only on CR; req1 asserts 0x58 throughout. Expect:
  - Bytes out 0x48,0x49,0x0D,0x58.
  - locked=1 from the first ack until the CR ack.
  - rr_ptr=1 after CR.
- Locked stall: req0 sends a byte with last=0, then drops req for 50 clks while req1 is active. Expect no tx_start for 50 clks, locked=1; req1 is served only after req0 completes with last=1.
- Reset mid-frame: assert reset while in START. Expect tx_start=0, ack=0, locked=0, grant_id=0 immediately; normal grant resumes after deassert.
- Early tx_busy: stub holds tx_busy=1 already at tx_start. Expect START lasts 1 clk and tx_start is high for exactly 1 clk.
